// File: rtl/wb_pkg.sv
// Shared types for the write-back select stage: load sizes, skid FSM states
// and the staged beat layout at the default widths.
package wb_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } wb_state_e;

    localparam int WB_XLEN   = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_XLEN-1:0]   data;
        logic [WB_ADDR_W-1:0] addr;
        logic                 we;
    } wb_beat_t;

    // Raw 2-bit load size: both 10 and 11 mean a full word.
    function automatic load_size_e decode_load_size(input logic [1:0] raw);
        if (raw[1]) begin
            return LS_WORD;
        end
        return raw[0] ? LS_HALF : LS_BYTE;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/half lane select and sign/zero extension for sub-word loads.
// Purely combinational; word loads pass through untouched.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] din,
    input  logic [1:0]      byte_off,
    input  load_size_e      load_size,
    input  logic            load_uns,
    output logic [XLEN-1:0] dout
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_fill;
    logic        half_fill;

    always_comb begin
        byte_lane = din[{byte_off, 3'b000} +: 8];
        // Halfword lane comes from byte_off[1] only; misaligned offsets round down.
        half_lane = din[{byte_off[1], 4'b0000} +: 16];
        byte_fill = ~load_uns & byte_lane[7];
        half_fill = ~load_uns & half_lane[15];
        dout      = din;
        case (load_size)
            LS_BYTE: dout = {{(XLEN-8){byte_fill}}, byte_lane};
            LS_HALF: dout = {{(XLEN-16){half_fill}}, half_lane};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back select stage: source mux, load extension, x0/illegal-select gating,
// and a 2-entry skid buffer (head + skid) feeding the register-file write port.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int MEM_SRC = 2,
    parameter int ADDR_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              load_size,
    input  logic                    load_uns,
    input  logic [1:0]              byte_off,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_we,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [XLEN-1:0]         wb_data,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic                    wb_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    fwd_valid,
    output logic [ADDR_W-1:0]       fwd_addr,
    output logic [XLEN-1:0]         fwd_data,
    output logic                    sel_err
);

    localparam int NUM_SLOTS = 1 << SEL_W;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } beat_t;

    // Unused select codes map to zero so the mux never indexes out of range.
    logic [XLEN-1:0] src_arr [NUM_SLOTS];

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_src
        if (gi < NUM_SRC) begin : g_live
            assign src_arr[gi] = src_data[gi*XLEN +: XLEN];
        end else begin : g_pad
            assign src_arr[gi] = '0;
        end
    end

    logic            sel_bad;
    logic            mem_sel;
    logic [XLEN-1:0] ext_data;
    beat_t           beat_in;

    assign sel_bad = (32'(sel) >= 32'(NUM_SRC));
    assign mem_sel = (32'(sel) == 32'(MEM_SRC));

    load_extend #(
        .XLEN(XLEN)
    ) u_load_extend (
        .din       (src_arr[sel]),
        .byte_off  (byte_off),
        .load_size (decode_load_size(load_size)),
        .load_uns  (load_uns),
        .dout      (ext_data)
    );

    always_comb begin
        beat_in.data = mem_sel ? ext_data : src_arr[sel];
        if (sel_bad) begin
            beat_in.data = '0;
        end
        beat_in.addr = rd_addr;
        beat_in.we   = rd_we & (|rd_addr) & ~sel_bad;
    end

    wb_state_e state_reg, state_next;
    beat_t     head_reg, head_next;
    beat_t     skid_reg, skid_next;
    logic      in_ready_reg, in_ready_next;
    logic      sel_err_reg, sel_err_next;
    logic      accept;
    logic      pop;
    logic      head_valid;

    assign head_valid = (state_reg != EMPTY);
    assign accept     = in_valid & in_ready_reg;
    assign pop        = head_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            head_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
            sel_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            skid_reg     <= skid_next;
            in_ready_reg <= in_ready_next;
            sel_err_reg  <= sel_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        head_next    = head_reg;
        skid_next    = skid_reg;
        sel_err_next = accept & sel_bad;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    head_next  = beat_in;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    head_next = beat_in;
                end else if (accept) begin
                    state_next = TWO;
                    skid_next  = beat_in;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // Skid always drains into head before anything new is taken.
                if (pop) begin
                    state_next = ONE;
                    head_next  = skid_reg;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
        in_ready_next = (state_next != TWO);
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = head_valid;
    assign wb_data   = head_reg.data;
    assign wb_addr   = head_reg.addr;
    assign wb_en     = head_valid & head_reg.we;
    assign fwd_valid = head_valid & head_reg.we;
    assign fwd_addr  = head_reg.addr;
    assign fwd_data  = head_reg.data;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: default 4-source build plus a 3-source
// build for the illegal-select path.
module tb_wb_select_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-source instance
    logic [127:0] src4;
    logic [1:0]   sel4;
    logic [1:0]   load_size4;
    logic         load_uns4;
    logic [1:0]   byte_off4;
    logic [4:0]   rd_addr4;
    logic         rd_we4;
    logic         in_valid4;
    logic         in_ready4;
    logic [31:0]  wb_data4;
    logic [4:0]   wb_addr4;
    logic         wb_en4;
    logic         out_valid4;
    logic         out_ready4;
    logic         fwd_valid4;
    logic [4:0]   fwd_addr4;
    logic [31:0]  fwd_data4;
    logic         sel_err4;

    // 3-source instance
    logic [95:0]  src3;
    logic [1:0]   sel3;
    logic [4:0]   rd_addr3;
    logic         rd_we3;
    logic         in_valid3;
    logic         in_ready3;
    logic [31:0]  wb_data3;
    logic [4:0]   wb_addr3;
    logic         wb_en3;
    logic         out_valid3;
    logic         out_ready3;
    logic         fwd_valid3;
    logic [4:0]   fwd_addr3;
    logic [31:0]  fwd_data3;
    logic         sel_err3;

    wb_select_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src4),
        .sel       (sel4),
        .load_size (load_size4),
        .load_uns  (load_uns4),
        .byte_off  (byte_off4),
        .rd_addr   (rd_addr4),
        .rd_we     (rd_we4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .wb_data   (wb_data4),
        .wb_addr   (wb_addr4),
        .wb_en     (wb_en4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .fwd_valid (fwd_valid4),
        .fwd_addr  (fwd_addr4),
        .fwd_data  (fwd_data4),
        .sel_err   (sel_err4)
    );

    wb_select_pipe #(.NUM_SRC(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src3),
        .sel       (sel3),
        .load_size (2'b10),
        .load_uns  (1'b0),
        .byte_off  (2'b00),
        .rd_addr   (rd_addr3),
        .rd_we     (rd_we3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .wb_data   (wb_data3),
        .wb_addr   (wb_addr3),
        .wb_en     (wb_en3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .fwd_valid (fwd_valid3),
        .fwd_addr  (fwd_addr3),
        .fwd_data  (fwd_data3),
        .sel_err   (sel_err3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat on the 4-source instance with out_ready high; checks the head next cycle.
    task automatic send(input string tag, input logic [1:0] s, input logic [1:0] sz,
                        input logic uns, input logic [1:0] off, input logic [4:0] rd,
                        input logic we, input logic [31:0] exp_data, input logic exp_en);
        sel4       = s;
        load_size4 = sz;
        load_uns4  = uns;
        byte_off4  = off;
        rd_addr4   = rd;
        rd_we4     = we;
        in_valid4  = 1'b1;
        step();
        check({tag, ".data"}, wb_data4, exp_data);
        check({tag, ".en"}, 32'(wb_en4), 32'(exp_en));
        check({tag, ".addr"}, 32'(wb_addr4), 32'(rd));
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t lv [9] = '{
        '{2'b00, 1'b0, 2'd3, 32'hFFFF_FF80},
        '{2'b00, 1'b1, 2'd3, 32'h0000_0080},
        '{2'b01, 1'b0, 2'd2, 32'hFFFF_80FF},
        '{2'b01, 1'b0, 2'd3, 32'hFFFF_80FF},
        '{2'b01, 1'b1, 2'd0, 32'h0000_7F01},
        '{2'b00, 1'b0, 2'd2, 32'hFFFF_FFFF},
        '{2'b00, 1'b1, 2'd2, 32'h0000_00FF},
        '{2'b10, 1'b0, 2'd1, 32'h80FF_7F01},
        '{2'b11, 1'b1, 2'd0, 32'h80FF_7F01}
    };

    initial begin
        rst_n      = 1'b0;
        src4       = {32'h0000_1234, 32'h80FF_7F01, 32'hCAFE_0001, 32'h0000_0104};
        sel4       = 2'd0;
        load_size4 = 2'b10;
        load_uns4  = 1'b0;
        byte_off4  = 2'd0;
        rd_addr4   = 5'd0;
        rd_we4     = 1'b0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        src3       = {32'h80FF_7F01, 32'h0000_5555, 32'h0000_0200};
        sel3       = 2'd0;
        rd_addr3   = 5'd0;
        rd_we3     = 1'b0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;

        // Reset state
        step();
        step();
        check("rst.in_ready", 32'(in_ready4), 32'd1);
        check("rst.out_valid", 32'(out_valid4), 32'd0);
        check("rst.wb_en", 32'(wb_en4), 32'd0);
        check("rst.wb_data", wb_data4, 32'd0);
        check("rst.fwd_valid", 32'(fwd_valid4), 32'd0);
        check("rst.sel_err", 32'(sel_err4), 32'd0);
        rst_n = 1'b1;

        // ALU source, 1-cycle latency from EMPTY
        send("alu", 2'd3, 2'b00, 1'b0, 2'd0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
        check("alu.out_valid", 32'(out_valid4), 32'd1);
        check("alu.fwd_valid", 32'(fwd_valid4), 32'd1);
        check("alu.fwd_addr", 32'(fwd_addr4), 32'd5);
        check("alu.fwd_data", fwd_data4, 32'h0000_1234);

        // Back-to-back loads with extension, one beat per cycle
        for (int i = 0; i < 9; i++) begin
            send($sformatf("load%0d", i), 2'd2, lv[i].sz, lv[i].uns, lv[i].off,
                 5'd10, 1'b1, lv[i].exp, 1'b1);
        end
        // Non-memory sources ignore load size
        src4[127:96] = 32'hDEAD_BEEF;
        send("alu_noext", 2'd3, 2'b00, 1'b0, 2'd3, 5'd11, 1'b1, 32'hDEAD_BEEF, 1'b1);
        send("pc4", 2'd0, 2'b00, 1'b0, 2'd0, 5'd1, 1'b1, 32'h0000_0104, 1'b1);
        send("csr", 2'd1, 2'b01, 1'b0, 2'd0, 5'd2, 1'b1, 32'hCAFE_0001, 1'b1);
        in_valid4 = 1'b0;
        step();
        check("drain.out_valid", 32'(out_valid4), 32'd0);
        check("drain.wb_en", 32'(wb_en4), 32'd0);

        // Backpressure: A then B fill both slots, C is refused
        out_ready4 = 1'b0;
        sel4 = 2'd3; rd_we4 = 1'b1;
        src4[127:96] = 32'h0000_AAAA; rd_addr4 = 5'd7; in_valid4 = 1'b1;
        step();
        check("bp.a.in_ready", 32'(in_ready4), 32'd1);
        check("bp.a.data", wb_data4, 32'h0000_AAAA);
        src4[127:96] = 32'h0000_BBBB; rd_addr4 = 5'd8;
        step();
        check("bp.b.in_ready", 32'(in_ready4), 32'd0);
        check("bp.b.head", wb_data4, 32'h0000_AAAA);
        src4[127:96] = 32'h0000_CCCC; rd_addr4 = 5'd9;
        step();
        check("bp.c.in_ready", 32'(in_ready4), 32'd0);
        check("bp.c.head", wb_data4, 32'h0000_AAAA);
        check("bp.c.addr", 32'(wb_addr4), 32'd7);
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        check("bp.popa.en", 32'(wb_en4), 32'd1);
        step();
        check("bp.popb.data", wb_data4, 32'h0000_BBBB);
        check("bp.popb.addr", 32'(wb_addr4), 32'd8);
        check("bp.popb.in_ready", 32'(in_ready4), 32'd1);
        step();
        check("bp.empty", 32'(out_valid4), 32'd0);

        // x0 destination and explicit no-write still flow through
        send("x0", 2'd3, 2'b10, 1'b0, 2'd0, 5'd0, 1'b1, 32'h0000_CCCC, 1'b0);
        check("x0.out_valid", 32'(out_valid4), 32'd1);
        check("x0.fwd_valid", 32'(fwd_valid4), 32'd0);
        send("nowe", 2'd3, 2'b10, 1'b0, 2'd0, 5'd9, 1'b0, 32'h0000_CCCC, 1'b0);
        in_valid4 = 1'b0;
        step();

        // 3-source build: sel 3 is illegal
        sel3 = 2'd3; rd_addr3 = 5'd6; rd_we3 = 1'b1; in_valid3 = 1'b1;
        step();
        check("err.data", wb_data3, 32'd0);
        check("err.en", 32'(wb_en3), 32'd0);
        check("err.out_valid", 32'(out_valid3), 32'd1);
        check("err.pulse", 32'(sel_err3), 32'd1);
        sel3 = 2'd1;
        step();
        check("err.clear", 32'(sel_err3), 32'd0);
        check("err.csr", wb_data3, 32'h0000_5555);
        check("err.csr_en", 32'(wb_en3), 32'd1);
        in_valid3 = 1'b0;
        step();
        check("err.idle", 32'(sel_err3), 32'd0);

        // Async reset while both slots are full
        out_ready4 = 1'b0;
        sel4 = 2'd3; rd_we4 = 1'b1; rd_addr4 = 5'd12; in_valid4 = 1'b1;
        step();
        rd_addr4 = 5'd13;
        step();
        check("two.in_ready", 32'(in_ready4), 32'd0);
        in_valid4 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(out_valid4), 32'd0);
        check("arst.wb_en", 32'(wb_en4), 32'd0);
        check("arst.wb_data", wb_data4, 32'd0);
        check("arst.wb_addr", 32'(wb_addr4), 32'd0);
        check("arst.in_ready", 32'(in_ready4), 32'd1);
        check("arst.fwd_valid", 32'(fwd_valid4), 32'd0);
        step();
        rst_n = 1'b1;
        out_ready4 = 1'b1;
        step();
        check("post.wb_en", 32'(wb_en4), 32'd0);
        check("post.out_valid", 32'(out_valid4), 32'd0);
        step();
        check("post2.wb_en", 32'(wb_en4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
